// File: rtl/div_arb_pkg.sv
// div_arb_pkg: shared state encoding and default constants for the divider arbiter
package div_arb_pkg;
   typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_READY, DONE} state_e;
   localparam int DEF_NREQ = 3;
   localparam int DEF_WD = 26;
   localparam int DEF_WQ = 16;
   localparam int DEF_TIMEOUT = 64;
   localparam logic [63:0] SAT_ONES = '1;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, search starts one past the last served requester
//   req_i   request vector
//   ptr_i   index of the last served requester
//   pick_o  one-hot winner, 0 when no request
//   idx_o   winner index
module rr_arbiter #(
   parameter int NREQ = 3,
   localparam int WI = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [WI-1:0]   ptr_i,
   output logic [NREQ-1:0] pick_o,
   output logic [WI-1:0]   idx_o
);
   logic [WI-1:0] j;
   always_comb begin
      idx_o = '0;
      j = '0;
      // walk from farthest to nearest so the nearest requester after ptr_i is written last
      for (int k = NREQ; k >= 1; k--) begin
         j = WI'((int'(ptr_i) + k) % NREQ);
         if (req_i[j]) idx_o = j;
      end
      pick_o = (|req_i) ? NREQ'(1) << idx_o : '0;
   end
endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one sequential divider with div-by-zero and hang protection
//   clk, rst                    clock, synchronous active-high reset
//   req, req_dividend/divisor   per-requester level request and flattened operands
//   grant, done, result, err    owner, completion pulse, held quotient, saturation flag
//   arb_busy                    high outside IDLE
//   div_start/dividend/divisor  divider command side
//   div_busy/ready/quotient     divider response side
module div_arbiter
   import div_arb_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int WD = DEF_WD,
   parameter int WQ = DEF_WQ,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ*WD-1:0] req_dividend,
   input  logic [NREQ*WD-1:0] req_divisor,
   output logic [NREQ-1:0]  grant,
   output logic [NREQ-1:0]  done,
   output logic [WQ-1:0]    result,
   output logic             err,
   output logic             arb_busy,
   output logic             div_start,
   output logic [WD-1:0]    div_dividend,
   output logic [WD-1:0]    div_divisor,
   input  logic             div_busy,
   input  logic             div_ready,
   input  logic [WQ-1:0]    div_quotient
);
   localparam int WI = $clog2(NREQ);
   localparam int WT = $clog2(TIMEOUT + 1);
   localparam logic [WQ-1:0] SAT = SAT_ONES[WQ-1:0];
   state_e state_q, state_d;
   logic [WI-1:0] owner_q, owner_d, ptr_q, ptr_d, pick_idx;
   logic [NREQ-1:0] grant_q, grant_d, done_q, done_d, pick;
   logic [WQ-1:0] result_q, result_d, cap_q, cap_d;
   logic err_q, err_d, sat_q, sat_d, busy_q, start_q, start_d;
   logic [WD-1:0] dvd_q, dvd_d, dvs_q, dvs_d;
   logic [WT-1:0] cnt_q, cnt_d;
   logic [WD-1:0] dvd_arr [NREQ];
   logic [WD-1:0] dvs_arr [NREQ];
   for (genvar g = 0; g < NREQ; g++) begin : g_ops
      assign dvd_arr[g] = req_dividend[g*WD +: WD];
      assign dvs_arr[g] = req_divisor[g*WD +: WD];
   end
   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req_i (req),
      .ptr_i (ptr_q),
      .pick_o(pick),
      .idx_o (pick_idx)
   );
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d = ptr_q;
      grant_d = grant_q;
      done_d = '0;
      result_d = result_q;
      err_d = 1'b0;
      cap_d = cap_q;
      sat_d = sat_q;
      dvd_d = dvd_q;
      dvs_d = dvs_q;
      cnt_d = cnt_q;
      start_d = 1'b0;
      case (state_q)
         IDLE: if (|req) begin
            state_d = START;
            owner_d = pick_idx;
            grant_d = pick;
            dvd_d = dvd_arr[pick_idx];
            dvs_d = dvs_arr[pick_idx];
            // strobe is registered, so it is decided here to land exactly in START
            start_d = |dvs_arr[pick_idx];
         end
         START: begin
            cnt_d = '0;
            sat_d = ~|dvs_q;
            cap_d = SAT;
            state_d = |dvs_q ? WAIT_BUSY : DONE;
         end
         WAIT_BUSY, WAIT_READY: if (div_ready) begin
            cap_d = div_quotient;
            sat_d = 1'b0;
            state_d = DONE;
         end else if (cnt_q == WT'(TIMEOUT - 1)) begin
            cap_d = SAT;
            sat_d = 1'b1;
            state_d = DONE;
         end else begin
            cnt_d = cnt_q + 1'b1;
            state_d = (state_q == WAIT_BUSY && div_busy) ? WAIT_READY : state_q;
         end
         DONE: begin
            done_d = grant_q;
            result_d = cap_q;
            err_d = sat_q;
            grant_d = '0;
            ptr_d = owner_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q <= WI'(NREQ - 1);
         grant_q <= '0;
         done_q <= '0;
         result_q <= '0;
         err_q <= 1'b0;
         cap_q <= '0;
         sat_q <= 1'b0;
         busy_q <= 1'b0;
         start_q <= 1'b0;
         dvd_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q <= ptr_d;
         grant_q <= grant_d;
         done_q <= done_d;
         result_q <= result_d;
         err_q <= err_d;
         cap_q <= cap_d;
         sat_q <= sat_d;
         busy_q <= state_d != IDLE;
         start_q <= start_d;
         dvd_q <= dvd_d;
         dvs_q <= dvs_d;
         cnt_q <= cnt_d;
      end
   end
   assign grant = grant_q;
   assign done = done_q;
   assign result = result_q;
   assign err = err_q;
   assign arb_busy = busy_q;
   assign div_start = start_q;
   assign div_dividend = dvd_q;
   assign div_divisor = dvs_q;
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed stimulus with a transaction-level model and per-cycle output checks
module tb_div_arbiter;
   localparam int NREQ = 3;
   localparam int WD = 26;
   localparam int WQ = 16;
   localparam int TIMEOUT = 64;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NREQ-1:0] req = '0;
   logic [NREQ*WD-1:0] req_dividend = '0;
   logic [NREQ*WD-1:0] req_divisor = '0;
   logic [NREQ-1:0] grant, done;
   logic [WQ-1:0] result;
   logic err, arb_busy, div_start;
   logic [WD-1:0] div_dividend, div_divisor;
   logic div_busy, div_ready;
   logic [WQ-1:0] div_quotient;
   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int late_at = -1;
   int dmode = 0;
   int lat = 10;

   div_arbiter #(.NREQ(NREQ), .WD(WD), .WQ(WQ), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .req(req), .req_dividend(req_dividend), .req_divisor(req_divisor),
      .grant(grant), .done(done), .result(result), .err(err), .arb_busy(arb_busy),
      .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_busy(div_busy), .div_ready(div_ready), .div_quotient(div_quotient)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask

   // divider: dmode 0 busy then ready after lat, 1 hangs busy, 2 ready with busy, 3 ready without busy
   initial begin : divm
      int ph;
      logic [WQ-1:0] q;
      ph = 0;
      q = '0;
      div_busy = 1'b0;
      div_ready = 1'b0;
      div_quotient = '0;
      forever begin
         @(negedge clk);
         #1;
         div_ready = 1'b0;
         if (rst) begin
            ph = 0;
            div_busy = 1'b0;
         end else begin
            if (cyc == late_at) begin
               div_ready = 1'b1;
               div_busy = 1'b0;
               div_quotient = 16'h1234;
            end
            if (ph > 0) begin
               if (dmode == 0) begin
                  div_busy = ph < lat;
                  if (ph == lat) begin
                     div_ready = 1'b1;
                     div_quotient = q;
                  end
                  ph = (ph == lat) ? 0 : ph + 1;
               end else if (dmode == 1) begin
                  div_busy = 1'b1;
                  ph = 0;
               end else if (dmode == 2) begin
                  div_busy = ph == 1;
                  if (ph == 1) begin
                     div_ready = 1'b1;
                     div_quotient = q;
                  end
                  ph = (ph == 1) ? 2 : 0;
               end else begin
                  div_ready = 1'b1;
                  div_quotient = q;
                  ph = 0;
               end
            end
            if (div_start) begin
               q = WQ'(div_dividend / div_divisor);
               ph = 1;
            end
         end
      end
   end

   // model: one outstanding operation; grant g, done two cycles after ready/abort/zero-divisor decision
   initial begin : cmp
      bit act_op, found;
      int g, dn_at, own, ptr, i;
      logic [WD-1:0] a, b;
      logic [WQ-1:0] res, nres;
      bit nerr;
      act_op = 0; g = 0; dn_at = -1; own = 0; ptr = NREQ - 1; i = 0;
      a = '0; b = '0; res = '0; nres = '0; nerr = 0; found = 0;
      forever begin
         @(negedge clk);
         if (cyc == 0) continue;
         if (rst) begin
            act_op = 0; ptr = NREQ - 1; res = '0; dn_at = -1;
            chk("rst_grant", grant, 0);
            chk("rst_done", done, 0);
            chk("rst_result", result, 0);
            chk("rst_err", err, 0);
            chk("rst_busy", arb_busy, 0);
            chk("rst_start", div_start, 0);
            chk("rst_dividend", div_dividend, 0);
            chk("rst_divisor", div_divisor, 0);
         end else if (act_op) begin
            if (dn_at < 0 && cyc >= g + 2) begin
               if (div_ready) begin
                  dn_at = cyc + 1; nres = div_quotient; nerr = 0;
               end else if (cyc == g + 1 + TIMEOUT) begin
                  dn_at = cyc + 1; nres = '1; nerr = 1;
               end
            end
            if (cyc == dn_at) begin
               res = nres;
               chk("done", done, NREQ'(1) << own);
               chk("done_err", err, nerr);
               chk("done_result", result, res);
               chk("done_grant", grant, 0);
               chk("done_busy", arb_busy, 0);
               chk("done_start", div_start, 0);
               act_op = 0;
               ptr = own;
            end else begin
               chk("op_grant", grant, NREQ'(1) << own);
               chk("op_done", done, 0);
               chk("op_err", err, 0);
               chk("op_result", result, res);
               chk("op_busy", arb_busy, 1);
               chk("op_start", div_start, (cyc == g) && (b != 0));
               chk("op_dividend", div_dividend, a);
               chk("op_divisor", div_divisor, b);
            end
         end else begin
            found = 0;
            for (int k = 1; k <= NREQ; k++) begin
               i = (ptr + k) % NREQ;
               if (req[i] && !found) begin
                  found = 1; own = i;
               end
            end
            if (found) begin
               a = req_dividend[own*WD +: WD];
               b = req_divisor[own*WD +: WD];
               g = cyc; act_op = 1;
               dn_at = (b == 0) ? g + 2 : -1;
               nres = '1; nerr = 1;
               chk("grant", grant, NREQ'(1) << own);
               chk("grant_start", div_start, b != 0);
               chk("grant_dividend", div_dividend, a);
               chk("grant_divisor", div_divisor, b);
               chk("grant_busy", arb_busy, 1);
            end else begin
               chk("idle_grant", grant, 0);
               chk("idle_busy", arb_busy, 0);
               chk("idle_start", div_start, 0);
            end
            chk("idle_done", done, 0);
            chk("idle_err", err, 0);
            chk("idle_result", result, res);
         end
      end
   end

   task automatic set_op(input int i, input logic [WD-1:0] dvd, input logic [WD-1:0] dvs);
      req_dividend[i*WD +: WD] = dvd;
      req_divisor[i*WD +: WD] = dvs;
   endtask

   task automatic wait_grant(output int at, output logic [NREQ-1:0] gr);
      at = -1; gr = '0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (grant != 0) begin
            at = cyc; gr = grant;
            return;
         end
      end
      chk("grant_wait_expired", 0, 1);
   endtask

   task automatic wait_done(output int at, output logic [NREQ-1:0] d, output logic [WQ-1:0] r, output logic e);
      at = -1; d = '0; r = '0; e = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (done != 0) begin
            at = cyc; d = done; r = result; e = err;
            return;
         end
      end
      chk("done_wait_expired", 0, 1);
   endtask

   initial begin : main
      int ga, da;
      logic [NREQ-1:0] gr, d;
      logic [WQ-1:0] r;
      logic e;
      int exp_order [6];
      exp_order = '{0, 1, 2, 0, 1, 2};
      repeat (3) @(negedge clk);
      #1 rst = 0;
      // single request, 10-cycle divider
      dmode = 0; lat = 10;
      set_op(1, 1000, 8);
      req = 3'b010;
      wait_grant(ga, gr);
      chk("t1_grant", gr, 3'b010);
      chk("t1_start", div_start, 1);
      wait_done(da, d, r, e);
      #1 req = 3'b000;
      chk("t1_done", d, 3'b010);
      chk("t1_result", r, 125);
      chk("t1_err", e, 0);
      chk("t1_latency", da - ga, 12);
      // fresh reset, all three requesting continuously
      repeat (2) @(negedge clk);
      #1 rst = 1;
      repeat (2) @(negedge clk);
      #1 rst = 0; lat = 3;
      set_op(0, 300, 3); set_op(1, 500, 5); set_op(2, 900, 3);
      req = 3'b111;
      for (int k = 0; k < 6; k++) begin
         wait_done(da, d, r, e);
         chk("t2_order", d, NREQ'(1) << exp_order[k]);
         chk("t2_result", r, (exp_order[k] == 2) ? 300 : 100);
      end
      #1 req = 3'b000;
      // divide by zero
      repeat (2) @(negedge clk);
      #1 set_op(2, 50, 0);
      req = 3'b100;
      wait_grant(ga, gr);
      chk("t3_grant", gr, 3'b100);
      chk("t3_start", div_start, 0);
      wait_done(da, d, r, e);
      #1 req = 3'b000;
      chk("t3_done", d, 3'b100);
      chk("t3_result", r, 16'hFFFF);
      chk("t3_err", e, 1);
      chk("t3_latency", da - ga, 2);
      // hung divider, then a stray late ready
      dmode = 1;
      set_op(0, 100, 4);
      req = 3'b001;
      wait_grant(ga, gr);
      wait_done(da, d, r, e);
      #1 req = 3'b000;
      chk("t4_done", d, 3'b001);
      chk("t4_result", r, 16'hFFFF);
      chk("t4_err", e, 1);
      chk("t4_latency", da - ga, TIMEOUT + 2);
      late_at = cyc + 2;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("t4_no_late_done", done, 0);
      end
      // reset during WAIT_READY; pointer restarts at requester 0
      #1 dmode = 0; lat = 20;
      set_op(2, 400, 4);
      req = 3'b100;
      wait_grant(ga, gr);
      repeat (5) @(negedge clk);
      #1 rst = 1;
      @(negedge clk);
      chk("t5_rst_grant", grant, 0);
      chk("t5_rst_done", done, 0);
      #1 rst = 0;
      set_op(0, 77, 7);
      req = 3'b101;
      wait_grant(ga, gr);
      chk("t5_grant", gr, 3'b001);
      wait_done(da, d, r, e);
      #1 req = 3'b000;
      chk("t5_result", r, 11);
      // fast dividers
      dmode = 2;
      set_op(1, 81, 9);
      req = 3'b010;
      wait_grant(ga, gr);
      wait_done(da, d, r, e);
      #1 req = 3'b000;
      chk("t6_done", d, 3'b010);
      chk("t6_result", r, 9);
      chk("t6_latency", da - ga, 3);
      dmode = 3;
      set_op(0, 64, 2);
      req = 3'b001;
      wait_grant(ga, gr);
      wait_done(da, d, r, e);
      #1 req = 3'b000;
      chk("t7_done", d, 3'b001);
      chk("t7_result", r, 32);
      chk("t7_err", e, 0);
      chk("t7_latency", da - ga, 3);
      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
